// File: rtl/sales_ledger_ctrl.sv
// Round-robin sale-event arbiter and per-product count/revenue accumulator.
// Define SALES_SATURATE_EN to saturate cnt/rev fields instead of wrapping.
module sales_ledger_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] qty,
  input  logic        clr,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic        upd_valid,
  output logic [1:0]  upd_id,
  output logic [31:0] cnt,
  output logic [47:0] rev,
  output logic [13:0] total_rev
);

  typedef enum logic [1:0] {IDLE, GRANT, ACCUM} state_t;

  state_t      state, state_next;
  logic [1:0]  sel, last_granted, winner, cand;
  logic        found;
  logic [3:0]  qty_lat, qty_win;
  logic [7:0]  prod;
  logic [7:0]  cnt_q [4];
  logic [11:0] rev_q [4];
  logic [7:0]  cnt_next;
  logic [11:0] rev_next;

  function automatic logic [7:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    price_of = 8'd12;
      2'd1:    price_of = 8'd15;
      2'd2:    price_of = 8'd2;
      default: price_of = 8'd3;
    endcase
  endfunction

  // Search starts one past the last winner so every requester is served in turn
  always_comb begin
    winner = last_granted;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_granted + 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
    qty_win = qty[{winner, 2'b00} +: 4];
  end

`ifdef SALES_SATURATE_EN
  logic [8:0]  cnt_sum;
  logic [12:0] rev_sum;

  always_comb begin
    cnt_sum  = {1'b0, cnt_q[sel]} + {5'b0, qty_lat};
    rev_sum  = {1'b0, rev_q[sel]} + {5'b0, prod};
    cnt_next = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    rev_next = rev_sum[12] ? 12'hFFF : rev_sum[11:0];
  end
`else
  always_comb begin
    cnt_next = cnt_q[sel] + {4'b0, qty_lat};
    rev_next = rev_q[sel] + {4'b0, prod};
  end
`endif

  always_comb begin
    state_next = state;
    gnt        = 4'b0000;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (req != 4'b0000) state_next = GRANT;
      GRANT: begin
        state_next = ACCUM;
        gnt[sel]   = 1'b1;
      end
      ACCUM:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clr) state_next = IDLE;
  end

  // clr takes precedence over arbitration and commit; last_granted and upd_id survive it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= 2'd0;
      qty_lat      <= 4'd0;
      last_granted <= 2'd3;
      prod         <= 8'd0;
      upd_valid    <= 1'b0;
      upd_id       <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 8'd0;
        rev_q[i] <= 12'd0;
      end
    end else begin
      state     <= state_next;
      upd_valid <= 1'b0;
      if (clr) begin
        for (int i = 0; i < 4; i++) begin
          cnt_q[i] <= 8'd0;
          rev_q[i] <= 12'd0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (req != 4'b0000) begin
              sel          <= winner;
              qty_lat      <= qty_win;
              last_granted <= winner;
            end
          end
          GRANT: prod <= price_of(sel) * {4'b0000, qty_lat};
          ACCUM: begin
            cnt_q[sel] <= cnt_next;
            rev_q[sel] <= rev_next;
            upd_id     <= sel;
            upd_valid  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign cnt       = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
  assign rev       = {rev_q[3], rev_q[2], rev_q[1], rev_q[0]};
  assign total_rev = {2'b00, rev_q[0]} + {2'b00, rev_q[1]}
                   + {2'b00, rev_q[2]} + {2'b00, rev_q[3]};

endmodule

// File: tb/tb_sales_ledger_ctrl.sv
// Directed self-checking bench for sales_ledger_ctrl (default or SALES_SATURATE_EN build).
module tb_sales_ledger_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] qty;
  logic        clr;
  logic [3:0]  gnt;
  logic        busy;
  logic        upd_valid;
  logic [1:0]  upd_id;
  logic [31:0] cnt;
  logic [47:0] rev;
  logic [13:0] total_rev;

  int total = 0;
  int bad   = 0;
  int cyc;

`ifdef SALES_SATURATE_EN
  localparam logic [7:0]  EXP_CNT1 = 8'd255;
  localparam logic [11:0] EXP_REV1 = 12'd4095;
`else
  localparam logic [7:0]  EXP_CNT1 = 8'd29;
  localparam logic [11:0] EXP_REV1 = 12'd179;
`endif

  sales_ledger_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .qty       (qty),
    .clr       (clr),
    .gnt       (gnt),
    .busy      (busy),
    .upd_valid (upd_valid),
    .upd_id    (upd_id),
    .cnt       (cnt),
    .rev       (rev),
    .total_rev (total_rev)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until a grant appears, giving up after 10 cycles
  task automatic wait_gnt(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (gnt == 4'b0000 && cycles < 10);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'h0);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_upd_valid"}, 64'(upd_valid), 64'h0);
    check({tag, "_upd_id"}, 64'(upd_id), 64'h0);
    check({tag, "_cnt"}, 64'(cnt), 64'h0);
    check({tag, "_rev"}, 64'(rev), 64'h0);
    check({tag, "_total"}, 64'(total_rev), 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    qty = 16'h0000;
    clr = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // single event on product 0, qty 5
    qty = 16'h0005;
    req = 4'b0001;
    wait_gnt(cyc);
    check("t1_gnt_latency", 64'(cyc), 64'd1);
    check("t1_gnt", 64'(gnt), 64'h1);
    check("t1_busy", 64'(busy), 64'h1);
    req = 4'b0000;
    tick();
    check("t1_gnt_pulse", 64'(gnt), 64'h0);
    check("t1_no_early_upd", 64'(upd_valid), 64'h0);
    tick();
    check("t1_upd_valid", 64'(upd_valid), 64'h1);
    check("t1_busy_low", 64'(busy), 64'h0);
    check("t1_cnt", 64'(cnt), 64'h0000_0005);
    check("t1_rev", 64'(rev), 64'h000_000_000_03C);
    check("t1_total", 64'(total_rev), 64'd60);
    check("t1_upd_id", 64'(upd_id), 64'h0);
    tick();
    check("t1_upd_pulse", 64'(upd_valid), 64'h0);

    // all four requesting, order must be 0,1,2,3 after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    qty = 16'h1111;
    req = 4'b1111;
    for (int id = 0; id < 4; id++) begin
      wait_gnt(cyc);
      check($sformatf("t2_gnt%0d", id), 64'(gnt), 64'(4'b0001 << id));
      check($sformatf("t2_gap%0d", id), 64'(cyc), (id == 0) ? 64'd1 : 64'd3);
      req[id] = 1'b0;
    end
    tick();
    tick();
    check("t2_upd_valid", 64'(upd_valid), 64'h1);
    check("t2_upd_id", 64'(upd_id), 64'h3);
    check("t2_cnt", 64'(cnt), 64'h0101_0101);
    check("t2_rev", 64'(rev), 64'h003_002_00F_00C);
    check("t2_total", 64'(total_rev), 64'd32);

    // fairness: after product 1, 0101 must go to product 2 first
    qty = 16'h1111;
    req = 4'b0010;
    wait_gnt(cyc);
    check("t3_gnt1", 64'(gnt), 64'h2);
    req = 4'b0000;
    tick();
    tick();
    req = 4'b0101;
    wait_gnt(cyc);
    check("t3_gnt2_first", 64'(gnt), 64'h4);
    req[2] = 1'b0;
    wait_gnt(cyc);
    check("t3_gnt0_second", 64'(gnt), 64'h1);
    check("t3_gap", 64'(cyc), 64'd3);
    req = 4'b0000;
    tick();
    tick();
    check("t3_total", 64'(total_rev), 64'd61);

    // clr then 19 x (product 1, qty 15)
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t4_clr_cnt", 64'(cnt), 64'h0);
    check("t4_clr_rev", 64'(rev), 64'h0);
    qty = 16'h00F0;
    for (int n = 0; n < 19; n++) begin
      req = 4'b0010;
      wait_gnt(cyc);
      req = 4'b0000;
      tick();
      tick();
    end
    check("t4_cnt1", 64'(cnt), 64'({EXP_CNT1, 8'h00}));
    check("t4_rev1", 64'(rev), 64'({EXP_REV1, 12'h000}));
    check("t4_total", 64'(total_rev), 64'(EXP_REV1));

    // clr during ACCUM of product 3 (qty 4) with rev3 = 6 beforehand
    clr = 1'b1;
    tick();
    clr = 1'b0;
    qty = 16'h2000;
    req = 4'b1000;
    wait_gnt(cyc);
    req = 4'b0000;
    tick();
    tick();
    check("t5_prior_rev3", 64'(rev), 64'h006_000_000_000);
    check("t5_prior_upd_id", 64'(upd_id), 64'h3);
    qty = 16'h4000;
    req = 4'b1000;
    wait_gnt(cyc);
    check("t5_gnt3", 64'(gnt), 64'h8);
    req = 4'b0000;
    tick();
    check("t5_in_accum", 64'(busy), 64'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_no_upd", 64'(upd_valid), 64'h0);
    check("t5_idle", 64'(busy), 64'h0);
    check("t5_cnt", 64'(cnt), 64'h0);
    check("t5_rev", 64'(rev), 64'h0);
    check("t5_total", 64'(total_rev), 64'h0);
    check("t5_upd_id_kept", 64'(upd_id), 64'h3);
    tick();
    check("t5_still_no_upd", 64'(upd_valid), 64'h0);
    check("t5_rev_after", 64'(rev), 64'h0);

    // rst during GRANT
    qty = 16'h0001;
    req = 4'b0001;
    wait_gnt(cyc);
    check("t6_gnt0", 64'(gnt), 64'h1);
    #3;
    rst = 1'b1;
    #1;
    check("t6_gnt_async_drop", 64'(gnt), 64'h0);
    check("t6_busy_async_drop", 64'(busy), 64'h0);
    req = 4'b0000;
    tick();
    check_reset_outputs("t6_reset");
    rst = 1'b0;
    qty = 16'h1111;
    req = 4'b1111;
    wait_gnt(cyc);
    check("t6_prio0", 64'(gnt), 64'h1);
    req = 4'b0000;
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sales_ledger_ctrl.md
# sales_ledger_ctrl

Sequencer and arbiter for the per-product revenue datapath of the vending machine. Four product channels raise sale events, each carrying a quantity. The block round-robin arbitrates among them, multiplies the granted quantity by a fixed unit price, and accumulates per-product sold counts and revenue for the display/report logic. It sits between the dispense logic (requesters) and the sales statistics display.

## Interface
- No parameters. Unit prices are fixed constants: product 0 = 12, product 1 = 15, product 2 = 2, product 3 = 3.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  per-product sale request; level, held until that product's gnt is seen.
- qty  in  16  packed quantities; product i at [4i+3:4i]; must be stable while req[i] is high.
- clr  in  1  synchronous clear of all statistics.
- gnt  out  4  one-hot grant; one-cycle pulse.
- busy  out  1  high whenever the FSM is not IDLE.
- upd_valid  out  1  one-cycle pulse when the accumulators have absorbed an event.
- upd_id  out  2  product index of the last committed event.
- cnt  out  32  packed sold counts; product i at [8i+7:8i].
- rev  out  48  packed revenue; product i at [12i+11:12i].
- total_rev  out  14  combinational sum of the four rev fields.

## Operation
- FSM states: IDLE, GRANT, ACCUM.
- IDLE: if req != 0, select the winner round-robin and go to GRANT. Otherwise stay.
  - Round-robin search starts at (last_granted + 1) mod 4.
  - last_granted resets to 3, so product 0 has priority first.
- At the IDLE -> GRANT edge, latch sel and qty[sel] and update last_granted.
  - gnt[sel] is high for the whole GRANT cycle.
  - The requester drops req after sampling gnt.
- GRANT -> ACCUM: register prod = price[sel] * qty_latched. prod is 8 bits; the maximum value is 225, so there is no overflow.
- ACCUM -> IDLE at the same edge:
  - cnt[sel] += qty_latched.
  - rev[sel] += prod.
  - upd_id <= sel.
  - upd_valid is high for the following cycle.
- qty = 0 event: arbitrated and granted normally, upd_valid still pulses, and values are unchanged.
- clr at any edge: zero all cnt and rev, force IDLE, and drive gnt and upd_valid low at that edge.
  - clr wins over a simultaneous commit.
  - An in-flight event that was already granted is discarded.
  - last_granted and upd_id are retained.
- Reset values:
  - FSM = IDLE.
  - gnt = 0, busy = 0, upd_valid = 0, upd_id = 0.
  - All cnt = 0, all rev = 0, so total_rev = 0.
  - last_granted = 3.
- Reset mid-operation aborts the in-flight event. No partial update is visible.

## Timing
- E0: IDLE sees req (and clr is low at E0). E0+1: gnt high, busy high. E0+2: prod registered. E0+3: cnt/rev updated, upd_valid high, busy low.
- Event latency is 3 cycles from the sampling edge to visible totals.
- Throughput is one event per 3 cycles. A new req is sampled at E0+3 at the earliest.
- Requests arriving while busy are held by the requester and arbitrated on the next IDLE edge.
- Simultaneous requests: exactly one grant per arbitration. Losers keep req high.
- total_rev follows rev combinationally, with no extra latency. Its width covers 4 × 4095 = 16380.

## Configuration
- SALES_SATURATE_EN defined: cnt saturates at 255 and rev at 4095, each independently per field.
- SALES_SATURATE_EN undefined: cnt wraps modulo 256 and rev wraps modulo 4096.
- The FSM and timing are identical in both builds.

## Test plan
- Reset, then req = 0001 with qty0 = 5.
  - Required: gnt = 0001 one cycle after the sampling edge; upd_valid 2 cycles later.
  - Required: cnt0 = 5, rev0 = 60, total_rev = 60, upd_id = 0.
- req = 1111 held, all qty = 1, each requester dropping req on its grant.
  - Required: grants in order 0, 1, 2, 3, each 3 cycles apart.
  - Required: rev = 12/15/2/3, total_rev = 32.
- Fairness: after serving product 1, present req = 0101.
  - Required: product 2 is granted before product 0.
- Product 1, qty = 15, repeated 19 times.
  - With macro: cnt1 = 255, rev1 = 4095.
  - Without macro: cnt1 = 29 (285 mod 256), rev1 = 179 (4275 mod 4096).
- clr asserted during ACCUM of a product 3 event (qty = 4), with prior rev3 = 6.
  - Required: all statistics = 0, no upd_valid pulse, FSM IDLE on the next cycle.
- rst asserted during GRANT.
  - Required: gnt drops immediately and all outputs return to reset values.
  - Required: after release, product 0 wins when req = 1111.
